// File: rtl/rr_arb8_enc.sv
// rr_arb8_enc: 8-way round-robin arbiter with registered one-hot grant,
// binary grant index and a one-cycle gap between consecutive grants.
//
// Parameters:
//   MAX_HOLD  - grant-hold cycle limit (1..15); only used with ARB_TIMEOUT_EN
// Ports:
//   clk       - clock, rising edge
//   rst       - asynchronous active-high reset
//   req       - request lines, bit n = requester n
//   done      - release strobe from the current owner (sampled in GRANT)
//   gnt       - registered one-hot grant, zero when nobody owns the bus
//   gnt_idx   - registered binary index of the owner, 0 when idle
//   gnt_valid - high while gnt is nonzero
//   timeout   - one-cycle pulse when a grant is revoked by the hold limit
// Build option:
//   ARB_TIMEOUT_EN - when defined, adds a 4-bit hold counter that revokes a
//                    grant after MAX_HOLD GRANT cycles; otherwise grants are
//                    held until released and timeout is tied low.
module rr_arb8_enc #(
   parameter int unsigned MAX_HOLD = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   input  logic       done,
   output logic [7:0] gnt,
   output logic [2:0] gnt_idx,
   output logic       gnt_valid,
   output logic       timeout
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GRANT = 2'd1,
      S_GAP   = 2'd2
   } state_e;

   state_e     state_q;
   logic [2:0] ptr_q;
   logic [7:0] gnt_q;
   logic [2:0] idx_q;
   logic       valid_q;

   logic       win_found;
   logic [2:0] win_idx;
   logic [2:0] cand;
   logic [7:0] win_onehot;
   logic       release_w;
   logic       limit_w;

   // Round-robin search: first set request at or after ptr, wrapping 7->0.
   always_comb begin
      win_found = 1'b0;
      win_idx   = ptr_q;
      cand      = ptr_q;
      for (int i = 0; i < 8; i++) begin
         cand = ptr_q + 3'(i);
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   assign win_onehot = 8'h01 << win_idx;

   // done and a dropped request collapse into one release.
   assign release_w = done | ~req[idx_q];

`ifdef ARB_TIMEOUT_EN
   logic [3:0] hold_q;
   logic [3:0] hold_inc;
   logic       to_q;

   localparam logic [3:0] HOLD_LIM = 4'(MAX_HOLD);

   assign hold_inc = hold_q + 4'd1;
   // Limit hits on the MAX_HOLD-th GRANT cycle; a release wins over it.
   assign limit_w  = (state_q == S_GRANT) && (hold_inc == HOLD_LIM);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_q <= 4'd0;
         to_q   <= 1'b0;
      end else begin
         to_q <= limit_w && !release_w;
         if (state_q == S_GRANT) begin
            hold_q <= hold_inc;
         end else begin
            hold_q <= 4'd0;
         end
      end
   end

   assign timeout = to_q;
`else
   logic unused_hold;

   assign unused_hold = |4'(MAX_HOLD);
   assign limit_w     = 1'b0;
   assign timeout     = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         ptr_q   <= 3'd0;
         gnt_q   <= 8'h00;
         idx_q   <= 3'd0;
         valid_q <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (win_found) begin
                  state_q <= S_GRANT;
                  ptr_q   <= win_idx + 3'd1;
                  gnt_q   <= win_onehot;
                  idx_q   <= win_idx;
                  valid_q <= 1'b1;
               end
            end
            S_GRANT: begin
               if (release_w || limit_w) begin
                  state_q <= S_GAP;
                  gnt_q   <= 8'h00;
                  idx_q   <= 3'd0;
                  valid_q <= 1'b0;
               end
            end
            S_GAP: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
               gnt_q   <= 8'h00;
               idx_q   <= 3'd0;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign gnt       = gnt_q;
   assign gnt_idx   = idx_q;
   assign gnt_valid = valid_q;

endmodule

// File: tb/tb_rr_arb8_enc.sv
// tb_rr_arb8_enc: directed vector bench for rr_arb8_enc.
// Table of {req, done, expected outputs} plus hand-written multi-cycle cases.
module tb_rr_arb8_enc;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] req;
   logic       done;
   logic [7:0] gnt;
   logic [2:0] gnt_idx;
   logic       gnt_valid;
   logic       timeout;

   always #5 clk = ~clk;

   rr_arb8_enc #(.MAX_HOLD(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .done      (done),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid),
      .timeout   (timeout)
   );

   typedef struct {
      logic [7:0] req;
      logic       done;
      logic [7:0] gnt;
      logic [2:0] idx;
      logic       vld;
   } vec_t;

   vec_t tv[64];
   int   nv = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic add(input logic [7:0] r, input logic d,
                      input logic [7:0] g, input logic [2:0] i,
                      input logic v);
      tv[nv] = '{r, d, g, i, v};
      nv++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [7:0] eg,
                      input logic [2:0] ei, input logic ev,
                      input logic et);
      n_cmp++;
      if ({gnt, gnt_idx, gnt_valid, timeout} !== {eg, ei, ev, et}) begin
         n_bad++;
         $display("FAIL %s: got gnt=%h idx=%0d vld=%b to=%b want gnt=%h idx=%0d vld=%b to=%b",
                  name, gnt, gnt_idx, gnt_valid, timeout, eg, ei, ev, et);
      end
   endtask

   initial begin
      logic [7:0] one;
      one = 8'h01;

      // fairness: FF held, done two cycles after each grant
      for (int k = 0; k < 9; k++) begin
         add(8'hFF, 1'b0, one << (k % 8), 3'(k % 8), 1'b1);
         add(8'hFF, 1'b0, one << (k % 8), 3'(k % 8), 1'b1);
         add(8'hFF, 1'b1, 8'h00, 3'd0, 1'b0);
         add(8'hFF, 1'b0, 8'h00, 3'd0, 1'b0);
      end
      // ptr=1 -> grant 5 leaves ptr=6
      add(8'h20, 1'b0, 8'h20, 3'd5, 1'b1);
      add(8'h00, 1'b0, 8'h00, 3'd0, 1'b0);
      add(8'h00, 1'b0, 8'h00, 3'd0, 1'b0);
      // wrap: ptr=6, req=41 -> 6 then 0
      add(8'h41, 1'b0, 8'h40, 3'd6, 1'b1);
      add(8'h41, 1'b1, 8'h00, 3'd0, 1'b0);
      add(8'h41, 1'b0, 8'h00, 3'd0, 1'b0);
      add(8'h41, 1'b0, 8'h01, 3'd0, 1'b1);
      add(8'h00, 1'b0, 8'h00, 3'd0, 1'b0);
      add(8'h00, 1'b0, 8'h00, 3'd0, 1'b0);
      // lone requester re-granted; done with req drop is one release
      add(8'h02, 1'b0, 8'h02, 3'd1, 1'b1);
      add(8'h02, 1'b1, 8'h00, 3'd0, 1'b0);
      add(8'h02, 1'b0, 8'h00, 3'd0, 1'b0);
      add(8'h02, 1'b0, 8'h02, 3'd1, 1'b1);
      add(8'h00, 1'b1, 8'h00, 3'd0, 1'b0);
      add(8'h00, 1'b0, 8'h00, 3'd0, 1'b0);
      // idle with no request, done ignored
      add(8'h00, 1'b0, 8'h00, 3'd0, 1'b0);
      add(8'h00, 1'b1, 8'h00, 3'd0, 1'b0);
      // grant 2 so ptr=3 for the hold case
      add(8'h04, 1'b0, 8'h04, 3'd2, 1'b1);
      add(8'h00, 1'b0, 8'h00, 3'd0, 1'b0);
      add(8'h00, 1'b0, 8'h00, 3'd0, 1'b0);

      // reset
      rst  = 1'b1;
      req  = 8'h00;
      done = 1'b0;
      #12;
      chk("reset_async", 8'h00, 3'd0, 1'b0, 1'b0);
      tick();
      chk("reset_held", 8'h00, 3'd0, 1'b0, 1'b0);
      rst = 1'b0;
      tick();
      chk("idle_after_reset", 8'h00, 3'd0, 1'b0, 1'b0);

      for (int i = 0; i < nv; i++) begin
         req  = tv[i].req;
         done = tv[i].done;
         tick();
         chk($sformatf("vec%0d", i), tv[i].gnt, tv[i].idx, tv[i].vld, 1'b0);
      end

`ifndef ARB_TIMEOUT_EN
      // hold: owner 3 keeps its grant for 20 cycles
      req  = 8'hFF;
      done = 1'b0;
      tick();
      chk("hold_grant", 8'h08, 3'd3, 1'b1, 1'b0);
      for (int i = 0; i < 20; i++) begin
         tick();
         chk($sformatf("hold_c%0d", i), 8'h08, 3'd3, 1'b1, 1'b0);
      end
      req = 8'hF7;
      tick();
      chk("hold_rel_gap", 8'h00, 3'd0, 1'b0, 1'b0);
      tick();
      chk("hold_idle", 8'h00, 3'd0, 1'b0, 1'b0);
      tick();
      chk("hold_next4", 8'h10, 3'd4, 1'b1, 1'b0);
      req = 8'h00;
      tick();
      chk("g4_rel", 8'h00, 3'd0, 1'b0, 1'b0);
      tick();
      chk("g4_idle", 8'h00, 3'd0, 1'b0, 1'b0);
`else
      // timeout: owner 3 never releases, MAX_HOLD=4
      req  = 8'hFF;
      done = 1'b0;
      tick();
      chk("to_grant", 8'h08, 3'd3, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("to_hold%0d", i), 8'h08, 3'd3, 1'b1, 1'b0);
      end
      tick();
      chk("to_revoke", 8'h00, 3'd0, 1'b0, 1'b1);
      tick();
      chk("to_idle", 8'h00, 3'd0, 1'b0, 1'b0);
      tick();
      chk("to_next4", 8'h10, 3'd4, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("lim_hold%0d", i), 8'h10, 3'd4, 1'b1, 1'b0);
      end
      done = 1'b1;
      tick();
      chk("lim_release", 8'h00, 3'd0, 1'b0, 1'b0);
      done = 1'b0;
      req  = 8'h00;
      tick();
      chk("lim_idle", 8'h00, 3'd0, 1'b0, 1'b0);
`endif

      // mid-grant reset on owner 5
      req = 8'hFF;
      tick();
      chk("pre_rst_g5", 8'h20, 3'd5, 1'b1, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_async", 8'h00, 3'd0, 1'b0, 1'b0);
      tick();
      chk("mid_rst_held", 8'h00, 3'd0, 1'b0, 1'b0);
      rst = 1'b0;
      tick();
      chk("post_rst_g0", 8'h01, 3'd0, 1'b1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
